inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Write-side counterpart to the 8-bit instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and writes it into a 256x8 instruction RAM starting at address 0.
- Exposes an asynchronous read port for the fetch stage.
- Drives cpu_hold so the core stays stalled while a program image is loading.

Parameters:
- ADDR_W, 8, instruction address width.
- DATA_W, 8, instruction/byte width.
- DEPTH, 256, RAM depth; must equal 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte this cycle.
- rd_addr  in  ADDR_W  fetch-side read address (the PC).
- rd_data  out  DATA_W  instruction at rd_addr, combinational.
- cpu_hold  out  1  stall the core; high from an accepted start until the session ends.
- load_done  out  1  high once a session finishes successfully; held until the next start.
- load_err  out  1  checksum failure (only with the optional feature); 0 otherwise.
- wr_count  out  ADDR_W+1  number of bytes written in the current or last session.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; in_ready=0, cpu_hold=0, load_done=0, load_err=0, wr_count=0.
  - RAM contents are not cleared.
- States: IDLE, LEN, LOAD, (CHK), DONE, (ERR).
- IDLE/DONE/ERR:
  - start=1 -> LEN next cycle.
  - cpu_hold=1 from that edge; load_done and load_err cleared; wr_count cleared.
  - start in any other state is ignored.
- LEN:
  - in_ready=1.
  - On a handshake (in_valid & in_ready), latch len=in_data. len=0 means 256.
  - Move to LOAD; internal address counter=0.
- LOAD:
  - in_ready=1.
  - Each handshake writes in_data to RAM[addr] at that posedge; addr++ and wr_count++.
  - The handshake that writes the final byte (wr_count reaches len) moves to DONE, or to CHK if the optional feature is on.
  - addr wraps 255->0 only after the 256th write, which is the terminal byte anyway.
- DONE:
  - in_ready=0, cpu_hold=0, load_done=1.
- Handshake rules:
  - in_ready depends only on state, never on in_valid.
  - Bytes offered while in_ready=0 are not consumed, and the producer must hold them.
  - One byte is consumed per cycle maximum, so back-to-back streaming runs at full rate.
- Read port:
  - rd_data=RAM[rd_addr], asynchronous.
  - A read and write to the same address in the same cycle returns the old data; the new data is visible the cycle after the edge.
- Reset asserted mid-load:
  - Immediate return to IDLE with cpu_hold=0.
  - Partially written RAM bytes remain; wr_count=0.
- in_valid held high across the LEN->LOAD transition: the next byte is treated as data; no bubble is required.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, state CHK with in_ready=1 accepts one trailer byte.
  - The trailer must equal the XOR of len and all data bytes.
  - Match -> DONE.
  - Mismatch -> ERR: load_err=1, cpu_hold stays 1, load_done=0. Only reset or a new start leaves ERR.
- Undefined:
  - No CHK/ERR states; the last data byte goes straight to DONE.
  - load_err is tied to 0.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, LEN, LOAD, CHK, DONE, ERR);
  - ADDR_W/DATA_W defaults;
  - the constant LEN_ZERO_MEANS_FULL=256.
- One sub-module, inst_ram: a DEPTH x DATA_W array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- The FSM, counters and checksum stay in the top module.

Test Plan:
- Reset/idle: reset low then high, no start -> in_ready=0, cpu_hold=0, load_done=0, wr_count=0. rd_addr=5 returns the pre-existing RAM content.
- Basic load: start, then stream 3,0xA1,0xB2,0xC3 with in_valid held high -> cpu_hold high for 4 cycles. Afterwards RAM[0..2]=A1,B2,C3, load_done=1, wr_count=3, cpu_hold=0.
- Backpressure/gaps: same image with in_valid toggling 1,0,1,0 -> identical RAM result. Bytes presented before start, or after DONE, are not consumed (in_ready=0).
- Full image: len byte 0x00 followed by 256 bytes with value=addr -> wr_count=256, RAM[255]=0xFF, load_done=1, no extra byte consumed.
- Mid-load reset: reset asserted after 2 of 4 bytes -> cpu_hold=0 immediately, state IDLE. A subsequent start and full reload succeeds.
- Checksum (LOADER_CHECKSUM_EN): image 2,0x10,0x20 with trailer 0x32 -> load_done=1. The same image with trailer 0x33 -> load_err=1, cpu_hold=1, load_done=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // A length byte of zero stands for a full 256-byte image.
  localparam int unsigned LEN_ZERO_MEANS_FULL = 256;

endpackage

// File: rtl/inst_ram.sv
// Instruction RAM: one synchronous write port and one asynchronous read port.
module inst_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents deliberately survive reset; a same-address read sees old data until the edge.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed byte image into instruction RAM and stalls the core while loading.
// Optional trailer checksum enabled with `define LOADER_CHECKSUM_EN.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   wr_count
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_wr_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_in_ready;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              w_hs;
  logic              w_we;
  logic              w_last;
  logic              w_start_ok;
  logic [ADDR_W:0]   w_cnt_inc;

  assign w_hs       = in_valid & r_in_ready;
  assign w_we       = w_hs & (r_state == LOAD);
  assign w_cnt_inc  = r_wr_count + (ADDR_W+1)'(1);
  assign w_last     = (w_cnt_inc == r_len);
  assign w_start_ok = start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERR));

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              r_load_err;

  // Running XOR of the length byte and every data byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_csum <= {DATA_W{1'b0}};
    end else if (w_hs && (r_state == LEN)) begin
      r_csum <= in_data;
    end else if (w_we) begin
      r_csum <= r_csum ^ in_data;
    end else begin
      r_csum <= r_csum;
    end
  end

  assign load_err = r_load_err;
`else
  assign load_err = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) w_next = LEN;
        else       w_next = r_state;
      end
      LEN: begin
        if (w_hs) w_next = LOAD;
        else      w_next = LEN;
      end
      LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_hs && w_last) w_next = CHK;
`else
        if (w_hs && w_last) w_next = DONE;
`endif
        else                w_next = LOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (w_hs) w_next = (in_data == r_csum) ? DONE : ERR;
        else      w_next = CHK;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // State, counters and status flags; flags are decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_len       <= {(ADDR_W+1){1'b0}};
      r_wr_count  <= {(ADDR_W+1){1'b0}};
      r_addr      <= {ADDR_W{1'b0}};
      r_in_ready  <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_load_err  <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == LEN) | (w_next == LOAD) | (w_next == CHK);
      r_cpu_hold  <= (w_next == LEN) | (w_next == LOAD) | (w_next == CHK) | (w_next == ERR);
      r_load_done <= (w_next == DONE);
`ifdef LOADER_CHECKSUM_EN
      r_load_err  <= (w_next == ERR);
`endif
      if (w_start_ok) begin
        r_wr_count <= {(ADDR_W+1){1'b0}};
        r_addr     <= {ADDR_W{1'b0}};
      end else if (w_hs && (r_state == LEN)) begin
        r_len  <= (in_data == {DATA_W{1'b0}}) ? (ADDR_W+1)'(LEN_ZERO_MEANS_FULL)
                                              : (ADDR_W+1)'(in_data);
        r_addr <= {ADDR_W{1'b0}};
      end else if (w_we) begin
        r_addr     <= r_addr + ADDR_W'(1);
        r_wr_count <= w_cnt_inc;
      end else begin
        r_addr     <= r_addr;
        r_wr_count <= r_wr_count;
      end
    end
  end

  inst_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_we),
    .waddr(r_addr),
    .wdata(in_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign in_ready  = r_in_ready;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed, table-driven bench for inst_mem_loader (handles LOADER_CHECKSUM_EN builds too).
module tb_inst_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [8:0] wr_count;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  inst_mem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err),
    .wr_count (wr_count)
  );

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_hold;
    logic       exp_done;
    logic [8:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ram(input logic [7:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check($sformatf("ram[%0d]", a), {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d,
                     input logic r, input logic h, input logic dn, input logic [8:0] c);
    tbl.push_back('{s, v, d, r, h, dn, c});
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("%s%0d.ready", tag, i), {31'd0, in_ready}, {31'd0, tbl[i].exp_ready});
      check($sformatf("%s%0d.hold", tag, i), {31'd0, cpu_hold}, {31'd0, tbl[i].exp_hold});
      check($sformatf("%s%0d.done", tag, i), {31'd0, load_done}, {31'd0, tbl[i].exp_done});
      check($sformatf("%s%0d.cnt", tag, i), {23'd0, wr_count}, {23'd0, tbl[i].exp_cnt});
      start    = tbl[i].start;
      in_valid = tbl[i].valid;
      in_data  = tbl[i].data;
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    tbl.delete();
  endtask

  // Start pulse, length byte, data bytes (and trailer if enabled), all back to back.
  task automatic load_image(input logic [7:0] len, input logic [7:0] base);
    logic [7:0] csum;
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    csum = len;
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = len;
    tick();
    for (int k = 0; k < n; k++) begin
      in_data = base + 8'(k);
      csum    = csum ^ in_data;
      tick();
    end
`ifdef LOADER_CHECKSUM_EN
    in_data = csum;
    tick();
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_addr  = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {31'd0, in_ready}, 32'd0);
    check("rst.hold", {31'd0, cpu_hold}, 32'd0);
    check("rst.done", {31'd0, load_done}, 32'd0);
    check("rst.err", {31'd0, load_err}, 32'd0);
    check("rst.cnt", {23'd0, wr_count}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    check("idle.ready", {31'd0, in_ready}, 32'd0);
    check("idle.hold", {31'd0, cpu_hold}, 32'd0);

    // Basic load; a byte offered before start and one after DONE must not be consumed.
    add(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 9'd0);
    add(1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 9'd0);
    add(1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 9'd0);
    add(1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 9'd1);
    add(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 9'd2);
`ifdef LOADER_CHECKSUM_EN
    add(1'b0, 1'b1, 8'hD3, 1'b1, 1'b1, 1'b0, 9'd3);
`endif
    add(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 9'd3);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'd3);
    run_table("basic");
    check_ram(8'd0, 8'hA1);
    check_ram(8'd1, 8'hB2);
    check_ram(8'd2, 8'hC3);
    tick();

    // Gappy valid; a stray start mid-load must be ignored.
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'd3);
    add(1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 9'd0);
    add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 9'd0);
    add(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 9'd0);
    add(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 9'd1);
    add(1'b0, 1'b1, 8'h6B, 1'b1, 1'b1, 1'b0, 9'd1);
    add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 9'd2);
    add(1'b0, 1'b1, 8'h7C, 1'b1, 1'b1, 1'b0, 9'd2);
`ifdef LOADER_CHECKSUM_EN
    add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 9'd3);
    add(1'b0, 1'b1, 8'h4E, 1'b1, 1'b1, 1'b0, 9'd3);
`endif
    add(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 9'd3);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'd3);
    run_table("gap");
    check_ram(8'd0, 8'h5A);
    check_ram(8'd1, 8'h6B);
    check_ram(8'd2, 8'h7C);
    tick();

    // Full 256-byte image, value = address.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("full.len_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    for (int k = 0; k < 256; k++) begin
      if (k == 255) begin
        check("full.cnt255", {23'd0, wr_count}, 32'd255);
        check("full.notdone", {31'd0, load_done}, 32'd0);
        check("full.hold", {31'd0, cpu_hold}, 32'd1);
      end
      in_data = 8'(k);
      tick();
    end
`ifdef LOADER_CHECKSUM_EN
    in_data = 8'h00;
    tick();
`endif
    in_data = 8'h99;
    check("full.done", {31'd0, load_done}, 32'd1);
    check("full.cnt", {23'd0, wr_count}, 32'd256);
    check("full.ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("full.noextra", {23'd0, wr_count}, 32'd256);
    in_valid = 1'b0;
    check_ram(8'd0, 8'h00);
    check_ram(8'd128, 8'h80);
    check_ram(8'd255, 8'hFF);
    tick();

    // Reset after 2 of 4 bytes.
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h04;
    tick();
    in_data = 8'hD0;
    tick();
    in_data = 8'hD1;
    tick();
    in_valid = 1'b0;
    check("mid.cnt2", {23'd0, wr_count}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("mid.hold", {31'd0, cpu_hold}, 32'd0);
    check("mid.ready", {31'd0, in_ready}, 32'd0);
    check("mid.cnt", {23'd0, wr_count}, 32'd0);
    check_ram(8'd0, 8'hD0);
    check_ram(8'd1, 8'hD1);
    check_ram(8'd2, 8'h02);
    check_ram(8'd5, 8'h05);
    reset = 1'b1;
    tick();
    check("mid.idle_hold", {31'd0, cpu_hold}, 32'd0);
    check("mid.idle_done", {31'd0, load_done}, 32'd0);
    load_image(8'd4, 8'h11);
    check("reload.done", {31'd0, load_done}, 32'd1);
    check("reload.cnt", {23'd0, wr_count}, 32'd4);
    check("reload.hold", {31'd0, cpu_hold}, 32'd0);
    check_ram(8'd0, 8'h11);
    check_ram(8'd3, 8'h14);
    check_ram(8'd4, 8'h04);
    tick();

`ifdef LOADER_CHECKSUM_EN
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h02;
    tick();
    in_data = 8'h10;
    tick();
    in_data = 8'h20;
    tick();
    in_data = 8'h32;
    tick();
    in_valid = 1'b0;
    check("csum_ok.done", {31'd0, load_done}, 32'd1);
    check("csum_ok.err", {31'd0, load_err}, 32'd0);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h02;
    tick();
    in_data = 8'h10;
    tick();
    in_data = 8'h20;
    tick();
    in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    check("csum_bad.err", {31'd0, load_err}, 32'd1);
    check("csum_bad.hold", {31'd0, cpu_hold}, 32'd1);
    check("csum_bad.done", {31'd0, load_done}, 32'd0);
    check("csum_bad.ready", {31'd0, in_ready}, 32'd0);
`else
    check("nocsum.err", {31'd0, load_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
